lc3_mmio_resp: RTL and testbench

Memory and memory-mapped I/O responder for the LC-3 core. It sits on the far side of the core's MAR/MDR memory port and answers each `mio_en` request with a one-cycle `ready` pulse. Addresses below xFE00 go to backing RAM with a configurable number of wait states. Addresses xFE00–xFE06 go to the keyboard and display device registers (KBSR/KBDR/DSR/DDR), which have valid/ready byte handshakes to the outside world.

---
 rtl/lc3_mmio_resp.sv | 192 +++++++++++++++++++
 tb/tb_lc3_mmio_resp.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mmio_resp.sv
// ============================================================================
// Module   : lc3_mmio_resp
// Brief    : LC-3 memory / memory-mapped I/O responder (RAM + KBSR/KBDR/DSR/DDR).
//            Optional interrupt outputs are built when LC3_MMIO_INT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lc3_mmio_resp #(
    parameter int WAIT_STATES = 2,
    parameter int MEM_AW      = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mio_en,
    input  logic        r_w,
    input  logic [15:0] mar,
    input  logic [15:0] mdr_in,
    output logic [15:0] mem_rdata,
    output logic        ready,
    input  logic [7:0]  kbd_data,
    input  logic        kbd_valid,
    output logic        kbd_ready,
    output logic [7:0]  disp_data,
    output logic        disp_valid,
    input  logic        disp_ready
`ifdef LC3_MMIO_INT_EN
    ,
    output logic        kbd_int,
    output logic        disp_int
`endif
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WAIT      = 2'd1;
    localparam logic [1:0] c_DONE      = 2'd2;
    localparam logic [3:0] c_WAIT_LOAD = WAIT_STATES[3:0];
    localparam int         c_DEPTH     = 1 << MEM_AW;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [3:0]        r_cnt;
    logic [7:0]        r_kbd_byte;
    logic [15:0]       r_mem [c_DEPTH];

    logic              w_dev;
    logic              w_commit;
    logic              w_wr;
    logic              w_rd;
    logic              w_ram_we;
    logic              w_kbsr;
    logic              w_kbdr;
    logic              w_dsr;
    logic              w_ddr;
    logic              w_kbd_ie;
    logic              w_disp_ie;
    logic [15:0]       w_rdata;
    logic [MEM_AW-1:0] w_ram_addr;

    assign w_dev      = (mar >= 16'hFE00);
    assign w_ram_addr = mar[MEM_AW-1:0];

    // State register and wait counter
    always_ff @(posedge clk) begin : p_state
        if (!rst) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == c_IDLE) begin
                r_cnt <= c_WAIT_LOAD;
            end else if (r_state == c_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // A request is not sampled during the ready cycle, so a requester still
    // holding mio_en high there is not mistaken for a new access.
    always_comb begin : p_next
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (mio_en && !ready) begin
                    w_next_state = (w_dev || (WAIT_STATES == 0)) ? c_DONE : c_WAIT;
                end
            end
            c_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin : p_out
        w_commit = (r_state == c_DONE);
        w_wr     = w_commit && r_w;
        w_rd     = w_commit && !r_w;
        w_ram_we = w_wr && !w_dev;
        w_kbsr   = (mar == 16'hFE00);
        w_kbdr   = (mar == 16'hFE02);
        w_dsr    = (mar == 16'hFE04);
        w_ddr    = (mar == 16'hFE06);
    end

    always_comb begin : p_rdata
        w_rdata = 16'h0000;
        if (!w_dev) begin
            w_rdata = r_mem[w_ram_addr];
        end else if (w_kbsr) begin
            w_rdata = {!kbd_ready, w_kbd_ie, 14'b0};
        end else if (w_kbdr) begin
            w_rdata = {8'b0, r_kbd_byte};
        end else if (w_dsr) begin
            w_rdata = {!disp_valid, w_disp_ie, 14'b0};
        end else if (w_ddr) begin
            w_rdata = {8'b0, disp_data};
        end
    end

    // Backing RAM is not reset; reset only blocks a pending write.
    always_ff @(posedge clk) begin : p_ram
        if (rst && w_ram_we) begin
            r_mem[w_ram_addr] <= mdr_in;
        end
    end

    always_ff @(posedge clk) begin : p_regs
        if (!rst) begin
            ready      <= 1'b0;
            mem_rdata  <= 16'h0000;
            kbd_ready  <= 1'b1;
            r_kbd_byte <= 8'h00;
            disp_valid <= 1'b0;
            disp_data  <= 8'h00;
        end else begin
            ready <= w_commit;
            if (w_rd) begin
                mem_rdata <= w_rdata;
            end
            if (w_rd && w_kbdr) begin
                kbd_ready <= 1'b1;
            end
            // Key arrival wins over a KBDR read-clear in the same cycle.
            if (kbd_valid && kbd_ready) begin
                kbd_ready  <= 1'b0;
                r_kbd_byte <= kbd_data;
            end
            if (disp_valid && disp_ready) begin
                disp_valid <= 1'b0;
            end else if (w_wr && w_ddr && !disp_valid) begin
                disp_valid <= 1'b1;
                disp_data  <= mdr_in[7:0];
            end
        end
    end

`ifdef LC3_MMIO_INT_EN
    logic r_kbd_ie;
    logic r_disp_ie;

    always_ff @(posedge clk) begin : p_int
        if (!rst) begin
            r_kbd_ie  <= 1'b0;
            r_disp_ie <= 1'b0;
            kbd_int   <= 1'b0;
            disp_int  <= 1'b0;
        end else begin
            if (w_wr && w_kbsr) begin
                r_kbd_ie <= mdr_in[14];
            end
            if (w_wr && w_dsr) begin
                r_disp_ie <= mdr_in[14];
            end
            kbd_int  <= !kbd_ready && r_kbd_ie;
            disp_int <= !disp_valid && r_disp_ie;
        end
    end

    assign w_kbd_ie  = r_kbd_ie;
    assign w_disp_ie = r_disp_ie;
`else
    assign w_kbd_ie  = 1'b0;
    assign w_disp_ie = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lc3_mmio_resp.sv
// ============================================================================
// Module   : tb_lc3_mmio_resp
// Brief    : Directed self-checking bench for lc3_mmio_resp (LC3_MMIO_INT_EN optional).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lc3_mmio_resp;

    localparam int WS      = 2;
    localparam int RAM_LAT = WS + 2;
    localparam int DEV_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mio_en;
    logic        r_w;
    logic [15:0] mar;
    logic [15:0] mdr_in;
    logic [15:0] mem_rdata;
    logic        ready;
    logic [7:0]  kbd_data;
    logic        kbd_valid;
    logic        kbd_ready;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic        disp_ready;
`ifdef LC3_MMIO_INT_EN
    logic        kbd_int;
    logic        disp_int;
`endif

    int vectors = 0;
    int errors  = 0;

    lc3_mmio_resp #(.WAIT_STATES(WS), .MEM_AW(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .mio_en     (mio_en),
        .r_w        (r_w),
        .mar        (mar),
        .mdr_in     (mdr_in),
        .mem_rdata  (mem_rdata),
        .ready      (ready),
        .kbd_data   (kbd_data),
        .kbd_valid  (kbd_valid),
        .kbd_ready  (kbd_ready),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready)
`ifdef LC3_MMIO_INT_EN
        ,
        .kbd_int    (kbd_int),
        .disp_int   (disp_int)
`endif
    );

    always #5 clk = ~clk;

    // Issue one access and wait (bounded) for ready; lat counts negedges after issue.
    task automatic do_access(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                             output logic [15:0] rdata, output int lat);
        @(negedge clk);
        mio_en = 1'b1; r_w = wr; mar = addr; mdr_in = wdata;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat = lat + 1;
            if (ready) break;
        end
        rdata  = mem_rdata;
        mio_en = 1'b0;
        r_w    = 1'b0;
    endtask

    task automatic test_reset;
        logic [15:0] rd;
        int lat;
        vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
        vectors++; if (mem_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h want 0000", mem_rdata); end
        vectors++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL reset_kbd_ready: got %b want 1", kbd_ready); end
        vectors++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_disp_valid: got %b want 0", disp_valid); end
        vectors++; if (disp_data !== 8'h00) begin errors++; $display("FAIL reset_disp_data: got %h want 00", disp_data); end
        do_access(1'b0, 16'hFE00, 16'h0000, rd, lat);
        vectors++; if (rd !== 16'h0000) begin errors++; $display("FAIL reset_kbsr: got %h want 0000", rd); end
        vectors++; if (lat !== DEV_LAT) begin errors++; $display("FAIL dev_latency: got %0d want %0d", lat, DEV_LAT); end
        do_access(1'b0, 16'hFE04, 16'h0000, rd, lat);
        vectors++; if (rd !== 16'h8000) begin errors++; $display("FAIL reset_dsr: got %h want 8000", rd); end
    endtask

    task automatic test_ram;
        logic [15:0] rd;
        int lat;
        do_access(1'b1, 16'h3000, 16'h1234, rd, lat);
        vectors++; if (lat !== RAM_LAT) begin errors++; $display("FAIL ram_wr_latency: got %0d want %0d", lat, RAM_LAT); end
        @(negedge clk);
        vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL ready_one_cycle: got %b want 0", ready); end
        do_access(1'b0, 16'h3000, 16'h0000, rd, lat);
        vectors++; if (lat !== RAM_LAT) begin errors++; $display("FAIL ram_rd_latency: got %0d want %0d", lat, RAM_LAT); end
        vectors++; if (rd !== 16'h1234) begin errors++; $display("FAIL ram_read: got %h want 1234", rd); end
    endtask

    task automatic test_alias;
        logic [15:0] rd;
        int lat;
        do_access(1'b1, 16'h3000, 16'hBEEF, rd, lat);
        vectors++; if (rd !== 16'h1234) begin errors++; $display("FAIL rdata_hold_on_write: got %h want 1234", rd); end
        do_access(1'b0, 16'h3400, 16'h0000, rd, lat);
        vectors++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL ram_alias: got %h want BEEF", rd); end
        do_access(1'b1, 16'h03FF, 16'h0A5A, rd, lat);
        do_access(1'b0, 16'hF7FF, 16'h0000, rd, lat);
        vectors++; if (rd !== 16'h0A5A) begin errors++; $display("FAIL ram_top_alias: got %h want 0A5A", rd); end
    endtask

    task automatic test_kbd;
        logic [15:0] rd;
        int lat;
        @(negedge clk);
        kbd_data = 8'h41; kbd_valid = 1'b1;
        @(negedge clk);
        vectors++; if (kbd_ready !== 1'b0) begin errors++; $display("FAIL kbd_ready_drop: got %b want 0", kbd_ready); end
        kbd_data = 8'h42;
        repeat (2) @(negedge clk);
        kbd_valid = 1'b0;
        do_access(1'b0, 16'hFE00, 16'h0000, rd, lat);
        vectors++; if (rd !== 16'h8000) begin errors++; $display("FAIL kbsr_full: got %h want 8000", rd); end
        do_access(1'b1, 16'hFE02, 16'h0099, rd, lat);
        do_access(1'b0, 16'hFE02, 16'h0000, rd, lat);
        vectors++; if (rd !== 16'h0041) begin errors++; $display("FAIL kbdr_read: got %h want 0041", rd); end
        do_access(1'b0, 16'hFE00, 16'h0000, rd, lat);
        vectors++; if (rd !== 16'h0000) begin errors++; $display("FAIL kbsr_cleared: got %h want 0000", rd); end
        vectors++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL kbd_ready_restored: got %b want 1", kbd_ready); end
        do_access(1'b1, 16'hFE00, 16'hBFFF, rd, lat);
        do_access(1'b0, 16'hFE00, 16'h0000, rd, lat);
        vectors++; if (rd !== 16'h0000) begin errors++; $display("FAIL kbsr_write_mask: got %h want 0000", rd); end
    endtask

    task automatic test_disp;
        logic [15:0] rd;
        int lat;
        disp_ready = 1'b0;
        do_access(1'b1, 16'hFE06, 16'h0048, rd, lat);
        vectors++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL ddr_valid: got %b want 1", disp_valid); end
        vectors++; if (disp_data !== 8'h48) begin errors++; $display("FAIL ddr_data: got %h want 48", disp_data); end
        do_access(1'b0, 16'hFE04, 16'h0000, rd, lat);
        vectors++; if (rd !== 16'h0000) begin errors++; $display("FAIL dsr_busy: got %h want 0000", rd); end
        do_access(1'b1, 16'hFE06, 16'h0049, rd, lat);
        do_access(1'b0, 16'hFE06, 16'h0000, rd, lat);
        vectors++; if (rd !== 16'h0048) begin errors++; $display("FAIL ddr_drop: got %h want 0048", rd); end
        // DDR write whose commit edge coincides with the handshake is dropped
        @(negedge clk);
        mio_en = 1'b1; r_w = 1'b1; mar = 16'hFE06; mdr_in = 16'h0050;
        @(negedge clk);
        disp_ready = 1'b1;
        @(negedge clk);
        vectors++; if (ready !== 1'b1) begin errors++; $display("FAIL ddr_race_ready: got %b want 1", ready); end
        vectors++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL ddr_race_valid: got %b want 0", disp_valid); end
        vectors++; if (disp_data !== 8'h48) begin errors++; $display("FAIL ddr_race_data: got %h want 48", disp_data); end
        mio_en = 1'b0; r_w = 1'b0; disp_ready = 1'b0;
        do_access(1'b1, 16'hFE06, 16'h0149, rd, lat);
        vectors++; if (disp_data !== 8'h49) begin errors++; $display("FAIL ddr_second: got %h want 49", disp_data); end
        disp_ready = 1'b1;
        @(negedge clk);
        vectors++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL disp_handshake: got %b want 0", disp_valid); end
        disp_ready = 1'b0;
        do_access(1'b0, 16'hFE04, 16'h0000, rd, lat);
        vectors++; if (rd !== 16'h8000) begin errors++; $display("FAIL dsr_ready: got %h want 8000", rd); end
    endtask

    task automatic test_other;
        logic [15:0] rd;
        int lat;
        do_access(1'b1, 16'hFE01, 16'hFFFF, rd, lat);
        do_access(1'b0, 16'hFE01, 16'h0000, rd, lat);
        vectors++; if (rd !== 16'h0000) begin errors++; $display("FAIL other_fe01: got %h want 0000", rd); end
        do_access(1'b0, 16'hFFFF, 16'h0000, rd, lat);
        vectors++; if (rd !== 16'h0000) begin errors++; $display("FAIL other_ffff: got %h want 0000", rd); end
        vectors++; if (lat !== DEV_LAT) begin errors++; $display("FAIL other_latency: got %0d want %0d", lat, DEV_LAT); end
    endtask

    task automatic test_back_to_back;
        int lat;
        int gap;
        @(negedge clk);
        mio_en = 1'b1; r_w = 1'b1; mar = 16'h3010; mdr_in = 16'hCAFE;
        lat = 0;
        while (!ready && lat < 40) begin @(negedge clk); lat++; end
        vectors++; if (lat !== RAM_LAT) begin errors++; $display("FAIL b2b_first: got %0d want %0d", lat, RAM_LAT); end
        r_w = 1'b0;
        gap = 0;
        do begin @(negedge clk); gap++; end while (!ready && gap < 40);
        vectors++; if (gap !== WS + 3) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", gap, WS + 3); end
        vectors++; if (mem_rdata !== 16'hCAFE) begin errors++; $display("FAIL b2b_read: got %h want CAFE", mem_rdata); end
        mio_en = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [15:0] rd;
        int lat;
        int pulses;
        @(negedge clk);
        mio_en = 1'b1; r_w = 1'b1; mar = 16'h3000; mdr_in = 16'h5555;
        repeat (2) @(negedge clk);
        rst = 1'b0; mio_en = 1'b0; r_w = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (ready) pulses++;
            @(negedge clk);
        end
        vectors++; if (pulses !== 0) begin errors++; $display("FAIL reset_mid_ready: got %0d pulses want 0", pulses); end
        vectors++; if (mem_rdata !== 16'h0000) begin errors++; $display("FAIL reset_mid_rdata: got %h want 0000", mem_rdata); end
        do_access(1'b0, 16'h3000, 16'h0000, rd, lat);
        vectors++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL reset_mid_ram: got %h want BEEF", rd); end
    endtask

`ifdef LC3_MMIO_INT_EN
    task automatic test_int;
        logic [15:0] rd;
        int lat;
        do_access(1'b1, 16'hFE00, 16'h4000, rd, lat);
        @(negedge clk);
        kbd_data = 8'h5A; kbd_valid = 1'b1;
        @(negedge clk);
        kbd_valid = 1'b0;
        vectors++; if (kbd_int !== 1'b0) begin errors++; $display("FAIL kbd_int_early: got %b want 0", kbd_int); end
        @(negedge clk);
        vectors++; if (kbd_int !== 1'b1) begin errors++; $display("FAIL kbd_int_set: got %b want 1", kbd_int); end
        do_access(1'b0, 16'hFE02, 16'h0000, rd, lat);
        vectors++; if (rd !== 16'h005A) begin errors++; $display("FAIL int_kbdr: got %h want 005A", rd); end
        @(negedge clk);
        vectors++; if (kbd_int !== 1'b0) begin errors++; $display("FAIL kbd_int_clear: got %b want 0", kbd_int); end
        do_access(1'b0, 16'hFE00, 16'h0000, rd, lat);
        vectors++; if (rd !== 16'h4000) begin errors++; $display("FAIL kbsr_ie: got %h want 4000", rd); end
        do_access(1'b1, 16'hFE04, 16'h4000, rd, lat);
        @(negedge clk);
        vectors++; if (disp_int !== 1'b1) begin errors++; $display("FAIL disp_int: got %b want 1", disp_int); end
        do_access(1'b1, 16'hFE04, 16'h0000, rd, lat);
        do_access(1'b1, 16'hFE00, 16'h0000, rd, lat);
    endtask
`endif

    initial begin
        rst = 1'b0; mio_en = 1'b0; r_w = 1'b0; mar = 16'h0000; mdr_in = 16'h0000;
        kbd_data = 8'h00; kbd_valid = 1'b0; disp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        test_reset;
        test_ram;
        test_alias;
        test_kbd;
        test_disp;
        test_other;
        test_back_to_back;
        test_reset_mid;
`ifdef LC3_MMIO_INT_EN
        test_int;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
